// File: rtl/pe_config_loader_if.sv
// Word stream from the bitstream producer into the PE configuration loader.
// The master drives data and valid. The slave returns ready.
interface pe_config_loader_if;
    logic [31:0] cfg_din;
    logic        cfg_din_v;
    logic        cfg_din_r;

    modport master (output cfg_din, output cfg_din_v, input cfg_din_r);
    modport slave  (input cfg_din, input cfg_din_v, output cfg_din_r);
endinterface

// File: rtl/pe_config_loader.sv
// Assembles 32-bit configuration words into one 144-bit bit image and one 6-bit enable image per PE,
// then strobes catch_config once so the whole array latches together.
module pe_config_loader #(
    parameter int NUM_PES      = 16,
    parameter int WORDS_PER_PE = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    pe_config_loader_if.slave       cfg,
    output logic [NUM_PES*144-1:0]  config_bits,
    output logic [NUM_PES*6-1:0]    config_enables,
    output logic                    catch_config,
    output logic                    busy,
    output logic                    done
);
    localparam int PE_W = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      word_cnt;
    logic [PE_W-1:0] pe_cnt;
    logic            accept;
    logic            last_word;
    logic            last_pe;

    // Ready is a pure state decode, so acceptance never feeds back through cfg_din_r.
    assign accept    = (state == LOAD) && cfg.cfg_din_v;
    assign last_word = (word_cnt == 3'(WORDS_PER_PE - 1));
    assign last_pe   = (pe_cnt == PE_W'(NUM_PES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        cfg.cfg_din_r = 1'b0;
        catch_config  = 1'b0;
        done          = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cfg.cfg_din_r = 1'b1;
                if (accept && last_word && last_pe) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                // Masked by reset so the PEs never latch an image that is being wiped.
                catch_config = !rst;
                state_next   = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_next == LOAD) || (state_next == COMMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            pe_cnt   <= '0;
        end else if ((state == IDLE) && start) begin
            word_cnt <= '0;
            pe_cnt   <= '0;
        end else if (accept) begin
            if (last_word) begin
                word_cnt <= '0;
                pe_cnt   <= last_pe ? '0 : pe_cnt + 1'b1;
            end else begin
                word_cnt <= word_cnt + 3'd1;
            end
        end
    end

    // Word 4 carries slot bits [159:128]. Only [149:128] are kept; the top ten bits are padding.
    always_ff @(posedge clk) begin
        if (rst) begin
            config_bits    <= '0;
            config_enables <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_PES; i++) begin
                if (pe_cnt == PE_W'(i)) begin
                    case (word_cnt)
                        3'd0: config_bits[i*144 +: 32]       <= cfg.cfg_din;
                        3'd1: config_bits[i*144 + 32 +: 32]  <= cfg.cfg_din;
                        3'd2: config_bits[i*144 + 64 +: 32]  <= cfg.cfg_din;
                        3'd3: config_bits[i*144 + 96 +: 32]  <= cfg.cfg_din;
                        3'd4: begin
                            config_bits[i*144 + 128 +: 16] <= cfg.cfg_din[15:0];
                            config_enables[i*6 +: 6]       <= cfg.cfg_din[21:16];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_config_loader.sv
// Directed bench for pe_config_loader: a NUM_PES=2 instance for the main sequence
// and a NUM_PES=1 instance for back-to-back loads.
module tb_pe_config_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a;
    logic start_b;

    pe_config_loader_if ia();
    pe_config_loader_if ib();

    logic [287:0] bits_a;
    logic [11:0]  en_a;
    logic         catch_a, busy_a, done_a;
    logic [143:0] bits_b;
    logic [5:0]   en_b;
    logic         catch_b, busy_b, done_b;

    pe_config_loader #(.NUM_PES(2), .WORDS_PER_PE(5)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cfg(ia.slave),
        .config_bits(bits_a), .config_enables(en_a),
        .catch_config(catch_a), .busy(busy_a), .done(done_a)
    );

    pe_config_loader #(.NUM_PES(1), .WORDS_PER_PE(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cfg(ib.slave),
        .config_bits(bits_b), .config_enables(en_b),
        .catch_config(catch_b), .busy(busy_b), .done(done_b)
    );

    int total = 0;
    int fails = 0;
    int catch_cnt_a = 0;
    int catch_cnt_b = 0;
    int base;

    always @(posedge clk) begin
        if (catch_a === 1'b1) catch_cnt_a++;
        if (catch_b === 1'b1) catch_cnt_b++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] w, input bit stall);
        int g;
        g = 0;
        ia.cfg_din   = w;
        ia.cfg_din_v = 1'b1;
        while (ia.cfg_din_r !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        if (g >= 20) chk("ready_timeout_a", 320'(ia.cfg_din_r), 320'(1));
        step();
        ia.cfg_din_v = 1'b0;
        if (stall) step();
    endtask

    task automatic send_b(input logic [31:0] w);
        int g;
        g = 0;
        ib.cfg_din   = w;
        ib.cfg_din_v = 1'b1;
        while (ib.cfg_din_r !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        if (g >= 20) chk("ready_timeout_b", 320'(ib.cfg_din_r), 320'(1));
        step();
        ib.cfg_din_v = 1'b0;
    endtask

    task automatic wait_done_a();
        int g;
        g = 0;
        while (done_a !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        chk("done_seen_a", 320'(done_a), 320'(1));
    endtask

    logic [287:0] img_cnt;
    logic [287:0] ones;
    logic [143:0] img_pa;
    logic [143:0] img_pb;

    initial begin
        img_cnt = {16'h000A, 32'h9, 32'h8, 32'h7, 32'h6, 16'h0005, 32'h4, 32'h3, 32'h2, 32'h1};
        ones    = '1;
        img_pa  = {16'hCDEF, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        img_pb  = {16'h1234, 32'hDEADBEEF, 32'h89ABCDEF, 32'h01234567, 32'h5A5A5A5A};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        ia.cfg_din = 32'hDEADBEEF; ia.cfg_din_v = 1'b1;
        ib.cfg_din = '0;           ib.cfg_din_v = 1'b0;

        // Reset held for two cycles with valid high.
        step();
        chk("rst_ready_c1", 320'(ia.cfg_din_r), 320'(0));
        step();
        chk("rst_ready", 320'(ia.cfg_din_r), 320'(0));
        chk("rst_catch", 320'(catch_a), 320'(0));
        chk("rst_done",  320'(done_a), 320'(0));
        chk("rst_busy",  320'(busy_a), 320'(0));
        chk("rst_bits",  320'(bits_a), 320'(0));
        chk("rst_en",    320'(en_a), 320'(0));
        rst = 1'b0;
        step();
        chk("idle_ready_with_valid", 320'(ia.cfg_din_r), 320'(0));
        chk("idle_bits_untouched", 320'(bits_a), 320'(0));
        ia.cfg_din_v = 1'b0;
        step();

        // Back-to-back load of 1..10; start in cycle 0.
        base = catch_cnt_a;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("b2b_ready_c1", 320'(ia.cfg_din_r), 320'(1));
        chk("b2b_busy_c1",  320'(busy_a), 320'(1));
        for (int k = 1; k <= 10; k++) begin
            ia.cfg_din   = 32'(k);
            ia.cfg_din_v = 1'b1;
            step();
        end
        ia.cfg_din_v = 1'b0;
        chk("b2b_catch_c11", 320'(catch_a), 320'(1));
        chk("b2b_ready_c11", 320'(ia.cfg_din_r), 320'(0));
        chk("b2b_done_c11",  320'(done_a), 320'(0));
        chk("b2b_busy_c11",  320'(busy_a), 320'(1));
        step();
        chk("b2b_done_c12",  320'(done_a), 320'(1));
        chk("b2b_catch_c12", 320'(catch_a), 320'(0));
        chk("b2b_busy_c12",  320'(busy_a), 320'(0));
        step();
        chk("b2b_done_c13",  320'(done_a), 320'(0));
        chk("b2b_pe0_w0",    320'(bits_a[31:0]), 320'(1));
        chk("b2b_pe0_hi16",  320'(bits_a[143:128]), 320'(16'h0005));
        chk("b2b_pe0_en",    320'(en_a[5:0]), 320'(0));
        chk("b2b_pe1_w0",    320'(bits_a[175:144]), 320'(6));
        chk("b2b_image",     320'(bits_a), 320'(img_cnt));
        chk("b2b_catch_cnt", 320'(catch_cnt_a), 320'(base + 1));

        // Same data with valid toggling, after clearing the staging image.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stall_pre_cleared", 320'(bits_a), 320'(0));
        base = catch_cnt_a;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 1; k <= 10; k++) send_a(32'(k), 1'b1);
        wait_done_a();
        step();
        chk("stall_image",     320'(bits_a), 320'(img_cnt));
        chk("stall_en",        320'(en_a), 320'(0));
        chk("stall_catch_cnt", 320'(catch_cnt_a), 320'(base + 1));

        // Start pulsed mid-load after three words.
        base = catch_cnt_a;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 1; k <= 3; k++) send_a(32'h100 + 32'(k), 1'b0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("ign_busy",  320'(busy_a), 320'(1));
        chk("ign_ready", 320'(ia.cfg_din_r), 320'(1));
        for (int k = 4; k <= 9; k++) send_a(32'h100 + 32'(k), 1'b0);
        chk("ign_no_catch_early", 320'(catch_cnt_a), 320'(base));
        chk("ign_ready_before_last", 320'(ia.cfg_din_r), 320'(1));
        send_a(32'h10A, 1'b0);
        chk("ign_catch_after_7", 320'(catch_a), 320'(1));
        step();
        chk("ign_done", 320'(done_a), 320'(1));
        step();
        chk("ign_pe0_w0",   320'(bits_a[31:0]), 320'(32'h101));
        chk("ign_pe0_hi16", 320'(bits_a[143:128]), 320'(16'h0105));
        chk("ign_pe1_w0",   320'(bits_a[175:144]), 320'(32'h106));
        chk("ign_pe1_hi16", 320'(bits_a[287:272]), 320'(16'h010A));

        // Reset after six words, then a fresh all-ones load.
        base = catch_cnt_a;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 1; k <= 6; k++) send_a(32'h55555555, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy",  320'(busy_a), 320'(0));
        chk("mid_rst_ready", 320'(ia.cfg_din_r), 320'(0));
        chk("mid_rst_bits",  320'(bits_a), 320'(0));
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 1; k <= 9; k++) send_a(32'hFFFFFFFF, 1'b0);
        chk("mid_rst_no_catch", 320'(catch_cnt_a), 320'(base));
        send_a(32'hFFFFFFFF, 1'b0);
        chk("mid_rst_catch", 320'(catch_a), 320'(1));
        wait_done_a();
        step();
        chk("ones_bits",    320'(bits_a), 320'(ones));
        chk("ones_en_pe0",  320'(en_a[5:0]), 320'(6'h3F));
        chk("ones_en_all",  320'(en_a), 320'(12'hFFF));
        chk("ones_catch_cnt", 320'(catch_cnt_a), 320'(base + 1));

        // Single-PE instance: restart in the cycle after done.
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        send_b(32'h11111111);
        send_b(32'h22222222);
        send_b(32'h33333333);
        send_b(32'h44444444);
        send_b(32'hABE5CDEF);
        chk("p1_catch", 320'(catch_b), 320'(1));
        step();
        chk("p1_done", 320'(done_b), 320'(1));
        step();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("p1_restart_busy",  320'(busy_b), 320'(1));
        chk("p1_restart_ready", 320'(ib.cfg_din_r), 320'(1));
        chk("p1_hold_bits", 320'(bits_b), 320'(img_pa));
        chk("p1_hold_en",   320'(en_b), 320'(6'h25));
        send_b(32'h5A5A5A5A);
        chk("p1_w0_new", 320'(bits_b[31:0]), 320'(32'h5A5A5A5A));
        chk("p1_w1_old", 320'(bits_b[63:32]), 320'(32'h22222222));
        send_b(32'h01234567);
        send_b(32'h89ABCDEF);
        send_b(32'hDEADBEEF);
        send_b(32'hFF1A1234);
        chk("p1_catch2", 320'(catch_b), 320'(1));
        step();
        chk("p1_done2",  320'(done_b), 320'(1));
        chk("p1_bits2",  320'(bits_b), 320'(img_pb));
        chk("p1_en2",    320'(en_b), 320'(6'h1A));
        chk("p1_catch_cnt", 320'(catch_cnt_b), 320'(2));
        step();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
